cmos_trig_sequencer: RTL and testbench
======================================

CMOS_TRIG_SEQUENCER -- requirements
Module: cmos_trig_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_W, default 32: width of the period counter and trig_period.
REQ-002 SHALL have parameter CNT_W, default 16: width of trig_width, frame_num, bg_frame_deci_n and frame_idx.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: level sampled only in IDLE; begins a run.
REQ-006 SHALL have port stop, input, 1 bit: single-cycle request to end the run after the current frame.
REQ-007 SHALL have port trig_period, input, PERIOD_W bits: frame period in clk cycles.
REQ-008 SHALL have port trig_width, input, CNT_W bits: trigger high time in clk cycles.
REQ-009 SHALL have port frame_num, input, CNT_W bits: frames per run; 0 means continuous.
REQ-010 SHALL have port bg_frame_deci_n, input, CNT_W bits: number of A/B frames between background frames.
REQ-011 SHALL have port cmos_trig_pulse, output, 1 bit: registered camera trigger.
REQ-012 SHALL have port frame_type, output, 2 bits: 00 = BG, 01 = A, 10 = B; 11 is never driven.
REQ-013 SHALL have port frame_idx, output, CNT_W bits: index of the current frame within the run.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-016 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-017 SHALL implement states IDLE, HIGH, LOW and DONE.
REQ-018 SHALL, in IDLE with start=1, latch trig_period, trig_width, frame_num and bg_frame_deci_n; later input changes SHALL NOT affect the run.
REQ-019 SHALL treat the configuration as invalid if trig_period<2, trig_width==0 or trig_width>=trig_period; on such a start it SHALL stay in IDLE and pulse cfg_err the next cycle.
REQ-020 SHALL, on a valid start at cycle N, enter HIGH at N+1 with cmos_trig_pulse=1, period counter=0 and frame_idx=0.
REQ-021 SHALL hold cmos_trig_pulse=1 for exactly trig_width cycles, then 0 in LOW until the period counter reaches trig_period-1.
REQ-022 SHALL place each rising edge of cmos_trig_pulse exactly trig_period cycles after the previous one, with no drift.
REQ-023 SHALL, at each period end, increment frame_idx and re-enter HIGH, unless the run is ending.
REQ-024 SHALL compute the phase as phase = frame_idx mod (bg_frame_deci_n+1), using a wrapping phase counter, not a divider.
REQ-025 SHALL set frame_type = BG when phase==0, A when phase is odd, and B when phase is even and nonzero.
REQ-026 SHALL update frame_type in the same cycle cmos_trig_pulse rises and hold it for the whole frame.
REQ-027 SHALL, with bg_frame_deci_n==0, output BG for every frame.
REQ-028 SHALL end the run at the end of the period in which frame_idx==frame_num-1, when frame_num!=0.
REQ-029 SHALL register a stop seen in HIGH or LOW; the current period SHALL complete, then the run ends, and no new rising edge SHALL be issued.
REQ-030 SHALL end the run at the same boundary, once, if stop coincides with the last frame's period end.
REQ-031 SHALL, on run end, enter DONE for one cycle with done=1 and cmos_trig_pulse=0, then return to IDLE.
REQ-032 SHALL NOT start a new run while in DONE, even if start=1.
REQ-033 SHALL ignore stop in IDLE and DONE.
REQ-034 SHALL wrap frame_idx modulo 2^CNT_W in continuous mode, with no other effect.

Reset
REQ-035 SHALL, while rst=1 on a clock edge, force state=IDLE, cmos_trig_pulse=0, frame_type=00, frame_idx=0, busy=0, done=0, cfg_err=0 and clear the stop latch.
REQ-036 SHALL abort a run immediately on mid-run reset, with no done pulse.
REQ-037 SHALL give rst priority over start and stop in the same cycle.

Verification
REQ-038 SHALL cover: period=10, width=3, frame_num=4, deci=2 -> pulse high cycles 1-3, 11-13, 21-23, 31-33; frame_type BG, A, B, BG; done at cycle 41.
REQ-039 SHALL cover: width=10, period=10 -> cfg_err pulse, busy stays 0, no trigger.
REQ-040 SHALL cover: frame_num=0, stop at cycle 25 with period=10 -> frame 2 completes, done at cycle 31, exactly 3 rising edges.
REQ-041 SHALL cover: deci=0, frame_num=3 -> frame_type 00 for all frames.
REQ-042 SHALL cover: rst asserted at cycle 15 of a run -> next cycle all outputs at reset values, no done pulse.
REQ-043 SHALL cover: config inputs changed mid-run, and start held high through DONE -> timing unchanged, no restart until back in IDLE.

Source files
------------

// File: rtl/cmos_trig_sequencer.sv
// cmos_trig_sequencer: periodic camera trigger generator with BG/A/B frame tagging
// Ports: clk/rst (sync, active-high); start/stop run control; trig_period, trig_width,
// frame_num (0 = continuous) and bg_frame_deci_n are latched at start. Outputs:
// cmos_trig_pulse, frame_type (00 BG, 01 A, 10 B), frame_idx, busy, done and cfg_err pulses.
module cmos_trig_sequencer #(
  parameter int PERIOD_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] trig_period,
  input  logic [CNT_W-1:0]    trig_width,
  input  logic [CNT_W-1:0]    frame_num,
  input  logic [CNT_W-1:0]    bg_frame_deci_n,
  output logic                cmos_trig_pulse,
  output logic [1:0]          frame_type,
  output logic [CNT_W-1:0]    frame_idx,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);
  localparam int W = PERIOD_W > CNT_W ? PERIOD_W : CNT_W;
  localparam logic [1:0] IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d, fnum_q, fnum_d, deci_q, deci_d;
  logic [CNT_W-1:0] idx_q, idx_d, phase_q, phase_d;
  logic stop_q, stop_d, done_q, done_d, err_q, err_d, pulse_q, pulse_d;
  logic cfg_ok, period_end, ending;
  always_comb begin
    cfg_ok = trig_period >= PERIOD_W'(2) && trig_width != '0 && W'(trig_width) < W'(trig_period);
    period_end = state_q == LOW && cnt_q == period_q - PERIOD_W'(1);
    // a stop arriving on the period-end cycle itself still ends the run at this boundary
    ending = stop_q || stop || (fnum_q != '0 && idx_q + CNT_W'(1) == fnum_q);
    state_d = state_q;
    period_d = period_q;
    cnt_d = cnt_q;
    width_d = width_q;
    fnum_d = fnum_q;
    deci_d = deci_q;
    idx_d = idx_q;
    phase_d = phase_q;
    stop_d = stop_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && cfg_ok) begin
        state_d = HIGH;
        period_d = trig_period;
        width_d = trig_width;
        fnum_d = frame_num;
        deci_d = bg_frame_deci_n;
        cnt_d = '0;
        idx_d = '0;
        phase_d = '0;
        stop_d = 1'b0;
      end
      err_d = start && !cfg_ok;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else begin
      stop_d = stop_q || stop;
      cnt_d = cnt_q + PERIOD_W'(1);
      if (state_q == HIGH && W'(cnt_q) + W'(1) == W'(width_q))
        state_d = LOW;
      if (period_end) begin
        state_d = ending ? DONE : HIGH;
        done_d = ending;
        stop_d = 1'b0;
        cnt_d = '0;
        idx_d = ending ? idx_q : idx_q + CNT_W'(1);
        // wrapping phase counter replaces frame_idx mod (deci+1)
        phase_d = ending ? phase_q : (phase_q == deci_q ? '0 : phase_q + CNT_W'(1));
      end
    end
    pulse_d = state_d == HIGH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      period_q <= '0;
      cnt_q <= '0;
      width_q <= '0;
      fnum_q <= '0;
      deci_q <= '0;
      idx_q <= '0;
      phase_q <= '0;
      stop_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      period_q <= period_d;
      cnt_q <= cnt_d;
      width_q <= width_d;
      fnum_q <= fnum_d;
      deci_q <= deci_d;
      idx_q <= idx_d;
      phase_q <= phase_d;
      stop_q <= stop_d;
      done_q <= done_d;
      err_q <= err_d;
      pulse_q <= pulse_d;
    end
  end
  assign cmos_trig_pulse = pulse_q;
  assign frame_type = phase_q == '0 ? 2'b00 : (phase_q[0] ? 2'b01 : 2'b10);
  assign frame_idx = idx_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_cmos_trig_sequencer.sv
// tb_cmos_trig_sequencer: scoreboard bench for cmos_trig_sequencer with directed and random runs
module tb_cmos_trig_sequencer;
  localparam int PW = 32, CW = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [PW-1:0] trig_period = '0;
  logic [CW-1:0] trig_width = '0, frame_num = '0, bg_frame_deci_n = '0;
  logic cmos_trig_pulse, busy, done, cfg_err;
  logic [1:0] frame_type;
  logic [CW-1:0] frame_idx;
  cmos_trig_sequencer #(.PERIOD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .trig_period(trig_period), .trig_width(trig_width),
    .frame_num(frame_num), .bg_frame_deci_n(bg_frame_deci_n),
    .cmos_trig_pulse(cmos_trig_pulse), .frame_type(frame_type), .frame_idx(frame_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // kind: 0 = trigger rise, 1 = done, 2 = cfg_err
  typedef struct {int k; int c; int ft; int fi; int w;} ev_t;
  ev_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  function automatic int ftype(int k, int d);
    int p = k % (d + 1);
    return p == 0 ? 0 : (p % 2 == 1 ? 1 : 2);
  endfunction
  task automatic chk(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask
  logic prev_p = 1'b0;
  int hi = 0, cur_w = 0;
  task automatic see(int k);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected event kind %0d at cycle %0d", k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.c != cyc ||
          (k == 0 && (e.ft != int'(frame_type) || e.fi != int'(frame_idx) || !busy)) ||
          (k == 1 && (cmos_trig_pulse || !busy)) || (k == 2 && busy)) begin
        n_err++;
        $display("FAIL event: got kind %0d cyc %0d type %0d idx %0d busy %0d pulse %0d, expected kind %0d cyc %0d type %0d idx %0d",
                 k, cyc, frame_type, frame_idx, busy, cmos_trig_pulse, e.k, e.c, e.ft, e.fi);
      end
      if (k == 0) cur_w = e.w;
    end
  endtask
  always @(negedge clk) begin
    if (cmos_trig_pulse && !prev_p) see(0);
    if (!cmos_trig_pulse && prev_p) chk("pulse_width", hi, cur_w);
    if (done) see(1);
    if (cfg_err) see(2);
    hi = cmos_trig_pulse ? hi + 1 : 0;
    prev_p = cmos_trig_pulse;
  end
  task automatic chk_reset(string tag);
    chk({tag, "_pulse"}, int'(cmos_trig_pulse), 0);
    chk({tag, "_type"}, int'(frame_type), 0);
    chk({tag, "_idx"}, int'(frame_idx), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask
  // xs/xr: stop/reset cycle relative to the start cycle (-1 = none)
  task automatic run(int t_p, int t_w, int f_n, int d_n, int xs, bit hold, bit chg, int xr);
    int p, nf, done_c, endc, m, x, rx, t;
    ev_t e;
    @(negedge clk);
    p = cyc;
    start = 1'b1;
    trig_period = PW'(t_p);
    trig_width = CW'(t_w);
    frame_num = CW'(f_n);
    bg_frame_deci_n = CW'(d_n);
    if (t_p < 2 || t_w == 0 || t_w >= t_p) begin
      e = '{2, p + 1, 0, 0, 0};
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    nf = f_n == 0 ? 1000 : f_n;
    x = xs < 0 ? -1 : p + xs;
    if (x >= 0 && x <= p + nf * t_p) nf = (x - p - 1) / t_p + 1;
    for (int k = 0; k < nf; k++) begin
      e = '{0, p + 1 + k * t_p, ftype(k, d_n), k, t_w};
      exp_q.push_back(e);
    end
    done_c = p + 1 + nf * t_p;
    e = '{1, done_c, 0, 0, 0};
    exp_q.push_back(e);
    rx = xr < 0 ? -1 : p + xr;
    endc = rx >= 0 ? rx + 1 : done_c + 1;
    m = chg ? p + 1 + int'($urandom_range(0, nf * t_p - 1)) : -1;
    do begin
      @(negedge clk);
      t = cyc;
      if (t == p + 1 && !hold) start = 1'b0;
      if (t == x) stop = 1'b1;
      if (t == x + 1) stop = 1'b0;
      if (t == m) begin
        trig_period = PW'($urandom_range(0, 20));
        trig_width = CW'($urandom_range(0, 20));
        frame_num = CW'($urandom_range(0, 9));
        bg_frame_deci_n = CW'($urandom_range(0, 5));
      end
      if (t == rx) begin
        rst = 1'b1;
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].c > rx) exp_q.delete(i);
      end
      if (t == rx + 1) begin
        chk_reset("midrun_rst");
        rst = 1'b0;
      end
    end while (t < endc);
    start = 1'b0;
    stop = 1'b0;
  endtask
  initial begin
    int t_p, t_w, f_n, xs;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    run(10, 3, 4, 2, -1, 0, 0, -1);
    run(10, 10, 4, 2, -1, 0, 0, -1);
    run(10, 3, 0, 2, 25, 0, 0, -1);
    run(7, 2, 3, 0, -1, 0, 0, -1);
    run(10, 3, 5, 2, -1, 0, 0, 15);
    run(6, 2, 3, 1, -1, 1, 1, -1);
    run(5, 4, 3, 1, 15, 0, 0, -1);
    run(2, 1, 4, 3, -1, 0, 0, -1);
    run(1, 1, 2, 0, -1, 0, 0, -1);
    run(8, 0, 2, 0, -1, 0, 0, -1);
    for (int r = 0; r < 30; r++) begin
      t_p = $urandom_range(0, 12);
      t_w = $urandom_range(0, t_p + 1);
      f_n = $urandom_range(0, 5);
      xs = (f_n == 0 || $urandom_range(0, 2) == 0) ?
           int'($urandom_range(1, (f_n == 0 ? 4 : f_n) * (t_p < 1 ? 1 : t_p) + 1)) : -1;
      run(t_p, t_w, f_n, $urandom_range(0, 4), xs, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), -1);
      @(negedge clk);
      stop = 1'($urandom_range(0, 1));
      @(negedge clk);
      stop = 1'b0;
    end
    repeat (5) @(negedge clk);
    chk("leftover_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
